uart_baud_ctrl: RTL and testbench
=================================

// Module: uart_baud_ctrl
// PURPOSE
//  Owns and sequences the UART baud generator's divisor. It holds baudDivisor and takes new values from software.
//  It only applies a change when the UART is idle, and it pulses the generator's reset so tick phase restarts cleanly.
//  Optional auto-baud measures a received 0x55 sync character and derives the divisor from it.
//  Sits between the UART register file and the baud generator; clock is the generator's 50 MHz reference.
// PARAMETERS
//  DEFAULT_DIVISOR  27  divisor loaded at reset (50 MHz / (16*115200))
//  HOLD_CYCLES      4   cycles baudReset is held per reload; legal range 1..15
//  MEAS_WIDTH       24  auto-baud cycle-counter width (16 + 7 + 1)
// PORTS
//  clock          in   1   system clock (50 MHz reference)
//  reset          in   1   asynchronous, active-high
//  cfgWrite       in   1   single-cycle strobe: request divisor = cfgData
//  cfgData        in   16  requested divisor
//  uartIdle       in   1   TX and RX both idle (no frame in progress)
//  cfgBusy        out  1   reload or auto-baud in progress; requests dropped
//  baudDivisor    out  16  divisor to baud generator
//  baudReset      out  1   reset to baud generator (restarts tick phase)
//  rxd            in   1   raw RX line (auto-baud only; unused without macro)
//  autoBaudStart  in   1   single-cycle strobe: start measurement
//  autoBaudDone   out  1   1-cycle pulse: measurement applied
//  autoBaudError  out  1   1-cycle pulse: measurement rejected
// BEHAVIOUR
//  Reset values: baudDivisor=DEFAULT_DIVISOR, baudReset=1, cfgBusy=1, done/error=0; state=HOLD, holdCnt=HOLD_CYCLES-1.
//  States: IDLE, WAIT_IDLE, HOLD, AB_WAIT_FALL, AB_MEASURE, AB_WAIT_STOP.
//  IDLE: cfgBusy=0, baudReset=0. On cfgWrite, latch pending = max(cfgData,2) (0/1 clamp to 2) and go to WAIT_IDLE.
//  WAIT_IDLE: when uartIdle=1, load baudDivisor=pending, assert baudReset, holdCnt=HOLD_CYCLES-1, go to HOLD.
//    baudDivisor changes in the same cycle baudReset rises.
//  HOLD: baudReset=1; decrement holdCnt; at 0 go to IDLE. baudReset is high for exactly HOLD_CYCLES cycles.
//  cfgWrite and autoBaudStart are ignored in any state other than IDLE; both together in IDLE: cfgWrite wins.
//  cfgBusy is registered: high from the cycle after an accepted request until the cycle after HOLD ends.
//  Async reset mid-operation: pending request lost; all outputs return to reset values at once.
// CONFIGURATION
//  UART_AUTOBAUD_EN defined:
//    rxd passes through 2 sync flops.
//    IDLE+autoBaudStart -> AB_WAIT_FALL.
//    First falling edge -> AB_MEASURE; count clear; edges=0.
//    Count every cycle; each further falling edge increments edges.
//    At edges==4 (8 bit times of 0x55): div=(count+64)>>7 (round to nearest) -> AB_WAIT_STOP.
//    AB_WAIT_STOP waits for rxd=1, then:
//      div in 2..65535: pending=div, go to WAIT_IDLE, pulse autoBaudDone when HOLD is entered.
//      otherwise: pulse autoBaudError, baudDivisor unchanged, go to IDLE.
//    Count saturating at 2^MEAS_WIDTH-1 -> autoBaudError, IDLE.
//  UART_AUTOBAUD_EN undefined:
//    AB_* states, counter and sync flops not built; rxd/autoBaudStart ignored; done/error tied 0.
// STRUCTURE
//  Package uart_baud_pkg: state enum, DIV_MIN=2, ROUND_BIAS=64, DIV_SHIFT=7, SYNC_FALL_EDGES=4.
//  One sub-module, uart_autobaud_meter (sync, edge detect, counter, rounding), instanced only under UART_AUTOBAUD_EN.
//  The FSM and divisor/hold registers stay in uart_baud_ctrl.
// TESTING
//  1 Reset release -> baudReset=1 for 4 cycles, baudDivisor=27, cfgBusy falls in the cycle after baudReset falls.
//  2 uartIdle=1, cfgWrite cfgData=325 -> baudDivisor=325 and baudReset high 4 cycles; cfgBusy 0 afterwards.
//  3 uartIdle=0, cfgWrite 54 -> baudDivisor stays 27; second cfgWrite 100 is dropped.
//    Raise uartIdle -> divisor becomes 54.
//  4 cfgWrite cfgData=0 -> baudDivisor=2; cfgWrite+autoBaudStart in same IDLE cycle -> only the write is performed.
//  5 [AUTOBAUD] 0x55 at 9600 baud (bit=5208 cycles) -> baudDivisor=326, one autoBaudDone pulse.
//    Same test at 115200 baud -> 27.
//  6 [AUTOBAUD] rxd held high after start; then reset during AB_MEASURE.
//    Held high: autoBaudError after count saturates; divisor unchanged.
//    Reset: immediately IDLE-path reset values, no done/error pulse.

Source files
------------

// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg
//   Shared definitions for the UART baud divisor controller.
//   - baudState_t     : controller FSM states
//   - DIV_MIN         : smallest divisor the baud generator accepts
//   - ROUND_BIAS      : half of 2^DIV_SHIFT, makes the auto-baud shift round to nearest
//   - DIV_SHIFT       : 8 bit times / 16 oversampling = divide by 128
//   - SYNC_FALL_EDGES : falling edges after the start edge in a 0x55 sync character
//   - clampDivisor()  : forces software requests of 0 or 1 up to DIV_MIN
package uart_baud_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WAIT_IDLE    = 3'd1,
      HOLD         = 3'd2,
      AB_WAIT_FALL = 3'd3,
      AB_MEASURE   = 3'd4,
      AB_WAIT_STOP = 3'd5
   } baudState_t;

   localparam int DIV_MIN         = 2;
   localparam int ROUND_BIAS      = 64;
   localparam int DIV_SHIFT       = 7;
   localparam int SYNC_FALL_EDGES = 4;

   function automatic logic [15:0] clampDivisor(input logic [15:0] requested);
      logic [15:0] result;
      if (requested < 16'(DIV_MIN)) begin
         result = 16'(DIV_MIN);
      end else begin
         result = requested;
      end
      return result;
   endfunction

endpackage

// File: rtl/uart_autobaud_meter.sv
// uart_autobaud_meter
//   Measures the length of a received 0x55 sync character for auto-baud.
//   Only compiled when UART_AUTOBAUD_EN is defined; without the macro this
//   file contributes nothing to the build.
// Ports
//   clock, reset   : 50 MHz reference, asynchronous active-high reset
//   rxd            : raw RX line (asynchronous to clock)
//   clear          : zero the cycle and edge counters
//   countEn        : advance the saturating cycle counter this cycle
//   edgeEn         : count falling edges this cycle
//   fallEdge       : synchronised falling edge seen on rxd
//   lineHigh       : synchronised rxd level
//   lastEdge       : the final falling edge of the sync character is seen now
//   saturated      : cycle counter has reached its maximum
//   measDivisor    : rounded divisor derived from the elapsed cycle count
`ifdef UART_AUTOBAUD_EN
module uart_autobaud_meter
   import uart_baud_pkg::*;
#(
   parameter int MEAS_WIDTH = 24
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rxd,
   input  logic                  clear,
   input  logic                  countEn,
   input  logic                  edgeEn,
   output logic                  fallEdge,
   output logic                  lineHigh,
   output logic                  lastEdge,
   output logic                  saturated,
   output logic [MEAS_WIDTH:0]   measDivisor
);

   localparam logic [MEAS_WIDTH-1:0] COUNT_MAX     = {MEAS_WIDTH{1'b1}};
   localparam logic [2:0]            LAST_EDGE_IDX = 3'(SYNC_FALL_EDGES - 1);
   localparam logic [MEAS_WIDTH:0]   BIAS          = (MEAS_WIDTH + 1)'(ROUND_BIAS);
   localparam logic [MEAS_WIDTH:0]   ONE           = (MEAS_WIDTH + 1)'(1);

   logic [1:0]            rxdSync_r;
   logic                  rxdPrev_r;
   logic [MEAS_WIDTH-1:0] count_r;
   logic [2:0]            edges_r;
   logic [MEAS_WIDTH:0]   elapsed_s;

   // Two-flop synchroniser plus a delayed copy for edge detection; idle line is high.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rxdSync_r <= 2'b11;
         rxdPrev_r <= 1'b1;
      end else begin
         rxdSync_r <= {rxdSync_r[0], rxd};
         rxdPrev_r <= rxdSync_r[1];
      end
   end

   // Saturating cycle counter and falling-edge counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_r <= {MEAS_WIDTH{1'b0}};
         edges_r <= 3'd0;
      end else if (clear) begin
         count_r <= {MEAS_WIDTH{1'b0}};
         edges_r <= 3'd0;
      end else begin
         if (countEn && (count_r != COUNT_MAX)) begin
            count_r <= count_r + {{(MEAS_WIDTH - 1){1'b0}}, 1'b1};
         end
         if (edgeEn && fallEdge && (edges_r != 3'b111)) begin
            edges_r <= edges_r + 3'd1;
         end
      end
   end

   assign fallEdge  = rxdPrev_r & ~rxdSync_r[1];
   assign lineHigh  = rxdSync_r[1];
   assign saturated = (count_r == COUNT_MAX);
   assign lastEdge  = edgeEn & fallEdge & (edges_r == LAST_EDGE_IDX);

   // The counter restarts on the cycle after the start edge, so the cycle in
   // which the last edge is seen adds one to give exactly 8 bit times.
   assign elapsed_s   = {1'b0, count_r} + ONE;
   assign measDivisor = (elapsed_s + BIAS) >> DIV_SHIFT;

endmodule
`endif

// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl
//   Owns the baud generator divisor. Software requests are applied only while
//   the UART is idle, and every reload holds the generator in reset for
//   HOLD_CYCLES cycles so the tick phase restarts cleanly.
//   Optional auto-baud (compile with UART_AUTOBAUD_EN) measures a received
//   0x55 character and derives the divisor from it.
// Ports
//   clock          : 50 MHz baud generator reference
//   reset          : asynchronous, active-high
//   cfgWrite       : one-cycle request strobe, divisor = cfgData
//   cfgData        : requested divisor (0 and 1 are raised to 2)
//   uartIdle       : TX and RX both idle
//   cfgBusy        : reload or auto-baud in progress
//   baudDivisor    : divisor to baud generator
//   baudReset      : reset to baud generator
//   rxd            : raw RX line (auto-baud only)
//   autoBaudStart  : one-cycle strobe, start a measurement (auto-baud only)
//   autoBaudDone   : one-cycle pulse when a measured divisor is applied
//   autoBaudError  : one-cycle pulse when a measurement is rejected
module uart_baud_ctrl
   import uart_baud_pkg::*;
#(
   parameter logic [15:0] DEFAULT_DIVISOR = 16'd27,
   parameter int          HOLD_CYCLES     = 4,
   parameter int          MEAS_WIDTH      = 24
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cfgWrite,
   input  logic [15:0] cfgData,
   input  logic        uartIdle,
   output logic        cfgBusy,
   output logic [15:0] baudDivisor,
   output logic        baudReset,
   input  logic        rxd,
   input  logic        autoBaudStart,
   output logic        autoBaudDone,
   output logic        autoBaudError
);

   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

   baudState_t  state_r;
   baudState_t  stateNext_s;
   logic [3:0]  holdCnt_r;
   logic [3:0]  holdCntNext_s;
   logic [15:0] pending_r;
   logic [15:0] pendingNext_s;
   logic [15:0] divisor_r;
   logic [15:0] divisorNext_s;
   logic        baudReset_r;
   logic        cfgBusy_r;

`ifdef UART_AUTOBAUD_EN
   localparam logic [MEAS_WIDTH:0] AB_DIV_MIN = (MEAS_WIDTH + 1)'(DIV_MIN);
   localparam logic [MEAS_WIDTH:0] AB_DIV_MAX = (MEAS_WIDTH + 1)'(65535);

   logic                abFall_s;
   logic                abLineHigh_s;
   logic                abLastEdge_s;
   logic                abSat_s;
   logic [MEAS_WIDTH:0] abDiv_s;
   logic                abClear_s;
   logic                abCountEn_s;
   logic                abEdgeEn_s;
   logic [MEAS_WIDTH:0] divMeas_r;
   logic [MEAS_WIDTH:0] divMeasNext_s;
   logic                abReq_r;
   logic                abReqNext_s;
   logic                abDonePulse_s;
   logic                abErrPulse_s;
   logic                autoBaudDone_r;
   logic                autoBaudError_r;

   // The counter also runs while waiting for the start edge and the stop bit,
   // so a silent or stuck line ends in an error instead of hanging.
   assign abCountEn_s = (state_r == AB_WAIT_FALL) || (state_r == AB_MEASURE) ||
                        (state_r == AB_WAIT_STOP);
   assign abEdgeEn_s  = (state_r == AB_MEASURE);

   uart_autobaud_meter #(
      .MEAS_WIDTH (MEAS_WIDTH)
   ) meter (
      .clock       (clock),
      .reset       (reset),
      .rxd         (rxd),
      .clear       (abClear_s),
      .countEn     (abCountEn_s),
      .edgeEn      (abEdgeEn_s),
      .fallEdge    (abFall_s),
      .lineHigh    (abLineHigh_s),
      .lastEdge    (abLastEdge_s),
      .saturated   (abSat_s),
      .measDivisor (abDiv_s)
   );
`endif

   // Next-state, pending divisor and hold counter decode.
   always_comb begin
      stateNext_s   = state_r;
      holdCntNext_s = holdCnt_r;
      pendingNext_s = pending_r;
      divisorNext_s = divisor_r;
`ifdef UART_AUTOBAUD_EN
      divMeasNext_s = divMeas_r;
      abReqNext_s   = abReq_r;
      abClear_s     = 1'b0;
      abDonePulse_s = 1'b0;
      abErrPulse_s  = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            if (cfgWrite) begin
               pendingNext_s = clampDivisor(cfgData);
               stateNext_s   = WAIT_IDLE;
`ifdef UART_AUTOBAUD_EN
               abReqNext_s   = 1'b0;
            end else if (autoBaudStart) begin
               stateNext_s   = AB_WAIT_FALL;
               abClear_s     = 1'b1;
`endif
            end else begin
               stateNext_s   = IDLE;
            end
         end
         WAIT_IDLE: begin
            if (uartIdle) begin
               divisorNext_s = pending_r;
               holdCntNext_s = HOLD_LOAD;
               stateNext_s   = HOLD;
`ifdef UART_AUTOBAUD_EN
               abDonePulse_s = abReq_r;
               abReqNext_s   = 1'b0;
`endif
            end else begin
               stateNext_s   = WAIT_IDLE;
            end
         end
         HOLD: begin
            if (holdCnt_r == 4'd0) begin
               stateNext_s   = IDLE;
            end else begin
               holdCntNext_s = holdCnt_r - 4'd1;
            end
         end
`ifdef UART_AUTOBAUD_EN
         AB_WAIT_FALL: begin
            if (abSat_s) begin
               abErrPulse_s = 1'b1;
               stateNext_s  = IDLE;
            end else if (abFall_s) begin
               abClear_s    = 1'b1;
               stateNext_s  = AB_MEASURE;
            end else begin
               stateNext_s  = AB_WAIT_FALL;
            end
         end
         AB_MEASURE: begin
            if (abSat_s) begin
               abErrPulse_s  = 1'b1;
               stateNext_s   = IDLE;
            end else if (abLastEdge_s) begin
               divMeasNext_s = abDiv_s;
               stateNext_s   = AB_WAIT_STOP;
            end else begin
               stateNext_s   = AB_MEASURE;
            end
         end
         AB_WAIT_STOP: begin
            if (abLineHigh_s) begin
               if ((divMeas_r >= AB_DIV_MIN) && (divMeas_r <= AB_DIV_MAX)) begin
                  pendingNext_s = divMeas_r[15:0];
                  abReqNext_s   = 1'b1;
                  stateNext_s   = WAIT_IDLE;
               end else begin
                  abErrPulse_s  = 1'b1;
                  stateNext_s   = IDLE;
               end
            end else if (abSat_s) begin
               abErrPulse_s = 1'b1;
               stateNext_s  = IDLE;
            end else begin
               stateNext_s  = AB_WAIT_STOP;
            end
         end
`endif
         default: begin
            stateNext_s = IDLE;
         end
      endcase
   end

   // FSM state, divisor and registered outputs. cfgBusy stays high for one
   // extra cycle after HOLD so it falls the cycle after baudReset falls.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= HOLD;
         holdCnt_r   <= HOLD_LOAD;
         pending_r   <= DEFAULT_DIVISOR;
         divisor_r   <= DEFAULT_DIVISOR;
         baudReset_r <= 1'b1;
         cfgBusy_r   <= 1'b1;
      end else begin
         state_r     <= stateNext_s;
         holdCnt_r   <= holdCntNext_s;
         pending_r   <= pendingNext_s;
         divisor_r   <= divisorNext_s;
         baudReset_r <= (stateNext_s == HOLD);
         cfgBusy_r   <= (stateNext_s != IDLE) || (state_r != IDLE);
      end
   end

   assign baudDivisor = divisor_r;
   assign baudReset   = baudReset_r;
   assign cfgBusy     = cfgBusy_r;

`ifdef UART_AUTOBAUD_EN
   // Auto-baud bookkeeping and result pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         divMeas_r       <= {(MEAS_WIDTH + 1){1'b0}};
         abReq_r         <= 1'b0;
         autoBaudDone_r  <= 1'b0;
         autoBaudError_r <= 1'b0;
      end else begin
         divMeas_r       <= divMeasNext_s;
         abReq_r         <= abReqNext_s;
         autoBaudDone_r  <= abDonePulse_s;
         autoBaudError_r <= abErrPulse_s;
      end
   end

   assign autoBaudDone  = autoBaudDone_r;
   assign autoBaudError = autoBaudError_r;
`else
   logic [MEAS_WIDTH+1:0] unusedAutobaud_s;

   assign unusedAutobaud_s = {rxd, autoBaudStart, {MEAS_WIDTH{1'b0}}};
   assign autoBaudDone     = 1'b0;
   assign autoBaudError    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_ctrl.sv
`timescale 1ns/1ps
module tb_uart_baud_ctrl;

`ifdef UART_AUTOBAUD_EN
   localparam int MEAS_W  = 16;
   localparam int BIT_CYC = 434;
`else
   localparam int MEAS_W  = 24;
`endif

   logic        clock         = 1'b0;
   logic        reset         = 1'b1;
   logic        cfgWrite      = 1'b0;
   logic [15:0] cfgData       = 16'd0;
   logic        uartIdle      = 1'b1;
   logic        rxd           = 1'b1;
   logic        autoBaudStart = 1'b0;
   logic        cfgBusy;
   logic [15:0] baudDivisor;
   logic        baudReset;
   logic        autoBaudDone;
   logic        autoBaudError;

   int nChecks = 0;
   int nFail   = 0;

   always #10 clock = ~clock;

   uart_baud_ctrl #(
      .DEFAULT_DIVISOR (16'd27),
      .HOLD_CYCLES     (4),
      .MEAS_WIDTH      (MEAS_W)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .cfgWrite      (cfgWrite),
      .cfgData       (cfgData),
      .uartIdle      (uartIdle),
      .cfgBusy       (cfgBusy),
      .baudDivisor   (baudDivisor),
      .baudReset     (baudReset),
      .rxd           (rxd),
      .autoBaudStart (autoBaudStart),
      .autoBaudDone  (autoBaudDone),
      .autoBaudError (autoBaudError)
   );

   task automatic check(input string tag, input string item,
                        input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s.%s observed=%0d expected=%0d", tag, item, obs, exp);
      end
   endtask

   // One-cycle request; inputs change on the falling edge.
   task automatic writeCfg(input logic [15:0] d, input logic withStart);
      cfgData       = d;
      cfgWrite      = 1'b1;
      autoBaudStart = withStart;
      @(negedge clock);
      cfgWrite      = 1'b0;
      autoBaudStart = 1'b0;
   endtask

   // Wait for baudReset, check the divisor, the 4-cycle pulse and cfgBusy release.
   task automatic expectReload(input string tag, input logic [15:0] expDiv,
                               input logic expDone);
      int waitCnt;
      int width;
      waitCnt = 0;
      while (baudReset !== 1'b1 && waitCnt < 200) begin
         @(negedge clock);
         waitCnt++;
      end
      check(tag, "rise", baudReset, 32'd1);
      check(tag, "div", baudDivisor, expDiv);
      check(tag, "done", autoBaudDone, expDone);
      width = 0;
      while (baudReset === 1'b1 && width < 50) begin
         width++;
         @(negedge clock);
      end
      check(tag, "width", width, 32'd4);
      check(tag, "busyLate", cfgBusy, 32'd1);
      check(tag, "doneOnce", autoBaudDone, 32'd0);
      @(negedge clock);
      check(tag, "busyOff", cfgBusy, 32'd0);
   endtask

   initial begin
      // Reset values while reset is held
      repeat (3) @(negedge clock);
      check("rst", "div", baudDivisor, 32'd27);
      check("rst", "baudReset", baudReset, 32'd1);
      check("rst", "busy", cfgBusy, 32'd1);
      check("rst", "done", autoBaudDone, 32'd0);
      check("rst", "error", autoBaudError, 32'd0);

      // 1: release -> 4-cycle hold at the default divisor
      reset = 1'b0;
      expectReload("t1", 16'd27, 1'b0);

      // 3: UART busy -> request waits, second request is dropped
      uartIdle = 1'b0;
      writeCfg(16'd54, 1'b0);
      writeCfg(16'd100, 1'b0);
      repeat (8) @(negedge clock);
      check("t3", "divHeld", baudDivisor, 32'd27);
      check("t3", "noReset", baudReset, 32'd0);
      check("t3", "busy", cfgBusy, 32'd1);
      uartIdle = 1'b1;
      expectReload("t3", 16'd54, 1'b0);
      repeat (8) @(negedge clock);
      check("t3", "dropped", baudDivisor, 32'd54);
      check("t3", "idleBusy", cfgBusy, 32'd0);

      // 2: idle UART, plain reload
      writeCfg(16'd325, 1'b0);
      expectReload("t2", 16'd325, 1'b0);

      // 4: clamp of 0, write+start together, clamp of 1
      writeCfg(16'd0, 1'b0);
      expectReload("t4zero", 16'd2, 1'b0);
      writeCfg(16'd500, 1'b1);
      expectReload("t4both", 16'd500, 1'b0);
      repeat (5) @(negedge clock);
      check("t4both", "busy", cfgBusy, 32'd0);
      check("t4both", "error", autoBaudError, 32'd0);
      writeCfg(16'd1, 1'b0);
      expectReload("t4one", 16'd2, 1'b0);

      // Async reset with a pending request: request is lost
      uartIdle = 1'b0;
      writeCfg(16'd777, 1'b0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      #1;
      check("midRst", "div", baudDivisor, 32'd27);
      check("midRst", "baudReset", baudReset, 32'd1);
      check("midRst", "busy", cfgBusy, 32'd1);
      @(negedge clock);
      reset = 1'b0;
      expectReload("midRst", 16'd27, 1'b0);
      uartIdle = 1'b1;
      repeat (10) @(negedge clock);
      check("midRst", "lost", baudDivisor, 32'd27);
      check("midRst", "quiet", baudReset, 32'd0);

`ifdef UART_AUTOBAUD_EN
      begin
         logic [7:0] syncChar;
         int waitCnt;
         logic sawError;
         syncChar = 8'h55;

         // 5: 0x55 at 115200 baud -> divisor 27 with one done pulse
         writeCfg(16'd100, 1'b0);
         expectReload("t5pre", 16'd100, 1'b0);
         writeCfg(16'd0, 1'b0);
         expectReload("t5pre2", 16'd2, 1'b0);
         autoBaudStart = 1'b1;
         @(negedge clock);
         autoBaudStart = 1'b0;
         repeat (20) @(negedge clock);
         rxd = 1'b0;
         repeat (BIT_CYC) @(negedge clock);
         for (int i = 0; i < 8; i++) begin
            rxd = syncChar[i];
            repeat (BIT_CYC) @(negedge clock);
         end
         rxd = 1'b1;
         expectReload("t5", 16'd27, 1'b1);

         // 6a: line held high -> error after saturation, divisor unchanged
         autoBaudStart = 1'b1;
         @(negedge clock);
         autoBaudStart = 1'b0;
         waitCnt  = 0;
         sawError = 1'b0;
         while (!sawError && waitCnt < 70000) begin
            @(negedge clock);
            waitCnt++;
            if (autoBaudError === 1'b1) begin
               sawError = 1'b1;
            end
         end
         check("t6held", "error", sawError, 32'd1);
         check("t6held", "div", baudDivisor, 32'd27);
         @(negedge clock);
         check("t6held", "errOnce", autoBaudError, 32'd0);

         // 6b: reset during measurement -> reset values, no pulses
         autoBaudStart = 1'b1;
         @(negedge clock);
         autoBaudStart = 1'b0;
         repeat (5) @(negedge clock);
         rxd = 1'b0;
         repeat (100) @(negedge clock);
         reset = 1'b1;
         #1;
         check("t6rst", "div", baudDivisor, 32'd27);
         check("t6rst", "baudReset", baudReset, 32'd1);
         check("t6rst", "busy", cfgBusy, 32'd1);
         check("t6rst", "error", autoBaudError, 32'd0);
         rxd = 1'b1;
         @(negedge clock);
         reset = 1'b0;
         expectReload("t6rst", 16'd27, 1'b0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
